// File: rtl/button_debouncer.sv
// Push-button debouncer: input sampling, four-state stability FSM and
// registered level/pulse/toggle/count outputs. Optional BUTTON_DEBOUNCER_SYNC_EN adds a 2-flop synchronizer.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button,
  output logic       level,
  output logic       pressed,
  output logic       released,
  output logic       toggle,
  output logic [7:0] press_count
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  logic sample;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  assign sample = sync2;
`else
  logic sync1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync1 <= 1'b0;
    else          sync1 <= button;
  end

  assign sample = sync1;
`endif

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic          level_n, pressed_n, released_n, toggle_n;
  logic [7:0]    press_count_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE_LOW;
      count       <= '0;
      level       <= 1'b0;
      pressed     <= 1'b0;
      released    <= 1'b0;
      toggle      <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      level       <= level_n;
      pressed     <= pressed_n;
      released    <= released_n;
      toggle      <= toggle_n;
      press_count <= press_count_n;
    end
  end

  // All outputs are next-state values so every output comes straight from a flop.
  always_comb begin
    state_n       = state;
    count_n       = count;
    level_n       = level;
    pressed_n     = 1'b0;
    released_n    = 1'b0;
    toggle_n      = toggle;
    press_count_n = press_count;
    unique case (state)
      IDLE_LOW: begin
        if (sample) begin
          state_n = WAIT_HIGH;
          count_n = CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sample) begin
          state_n = IDLE_LOW;
          count_n = '0;
        end else if (count == CNT_LAST) begin
          state_n       = IDLE_HIGH;
          count_n       = '0;
          level_n       = 1'b1;
          pressed_n     = 1'b1;
          toggle_n      = ~toggle;
          press_count_n = press_count + 8'd1;
        end else begin
          count_n = count + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sample) begin
          state_n = WAIT_LOW;
          count_n = CW'(1);
        end
      end
      WAIT_LOW: begin
        if (sample) begin
          state_n = IDLE_HIGH;
          count_n = '0;
        end else if (count == CNT_LAST) begin
          state_n    = IDLE_LOW;
          count_n    = '0;
          level_n    = 1'b0;
          released_n = 1'b1;
        end else begin
          count_n = count + CW'(1);
        end
      end
      default: begin
        state_n = IDLE_LOW;
        count_n = '0;
      end
    endcase
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, consecutive stable samples required before the debounced level changes; the legal range is 2..1048576.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 button  input  1  raw, bouncing, asynchronous push-button level (1 = pressed).
REQ-005 level  output  1  debounced button level.
REQ-006 pressed  output  1  single-cycle pulse on each debounced 0->1 transition.
REQ-007 released  output  1  single-cycle pulse on each debounced 1->0 transition.
REQ-008 toggle  output  1  flips on every pressed pulse; intended to drive the downstream latch enable.
REQ-009 press_count  output  8  number of pressed pulses since reset, modulo 256.

Function
REQ-010 The sample input (sample) shall be the synchronized button value, as defined in Configuration.
REQ-011 The FSM shall have exactly four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH and WAIT_LOW.
REQ-012 In IDLE_LOW, sample=1 shall move the FSM to WAIT_HIGH with counter=1; otherwise the FSM holds.
REQ-013 In WAIT_HIGH, sample=1 shall increment the counter, and sample=0 shall return the FSM to IDLE_LOW with counter=0 and no output change (bounce rejected).
REQ-014 In WAIT_HIGH, when sample=1 and counter=DEBOUNCE_CYCLES-1, the FSM shall enter IDLE_HIGH, clear the counter, and on that same edge set level=1 and pressed=1.
REQ-015 IDLE_HIGH and WAIT_LOW shall mirror REQ-012 to REQ-014 with the polarity inverted, setting level=0 and released=1.
REQ-016 The counter width shall be $clog2(DEBOUNCE_CYCLES+1) bits, and the counter shall never exceed DEBOUNCE_CYCLES-1.
REQ-017 The pressed and released outputs shall be registered, high for exactly one cycle, and never high in the same cycle.
REQ-018 On the edge where pressed=1 is registered, toggle shall invert and press_count shall increment, wrapping from 255 to 0.
REQ-019 Latency: with E0 as the first edge at which the first flop captures the new stable button value, level shall change at edge E0+1+DEBOUNCE_CYCLES when the synchronizer is enabled, and at E0+DEBOUNCE_CYCLES when it is disabled.
REQ-020 A bounce that lasts exactly one sample inside a WAIT state shall restart the count from zero, so the full DEBOUNCE_CYCLES stable samples are required again.
REQ-021 All outputs shall be driven only from flops, with no combinational path from button to any output.

Reset
REQ-022 While reset_n=0, the block shall hold state=IDLE_LOW, counter=0, level=0, pressed=0, released=0, toggle=0, press_count=0, and all sync/sample flops at 0.
REQ-023 Reset assertion mid-WAIT shall abort the count immediately, with no pulse emitted.
REQ-024 After reset_n deasserts with button held at 1, the block shall treat the input as a new press and pulse pressed after the REQ-019 latency.

Configuration
REQ-025 When macro BUTTON_DEBOUNCER_SYNC_EN is defined, button shall pass through a two-flop synchronizer and sample shall be the second flop's output.
REQ-026 When BUTTON_DEBOUNCER_SYNC_EN is undefined, button shall be registered by a single flop and sample shall be that flop's output, reducing latency by one cycle per REQ-019.
REQ-027 All other behaviour shall be identical whether or not BUTTON_DEBOUNCER_SYNC_EN is defined.

Verification (DEBOUNCE_CYCLES=4, BUTTON_DEBOUNCER_SYNC_EN defined)
REQ-028 Clean press: button 0->1 is held, captured at E0 -> level=1 and pressed=1 for one cycle at E0+5, toggle=1, press_count=1.
REQ-029 Bounce: button pattern 1,1,0,1,1,1,1 at successive edges -> no pulse until 4 consecutive 1 samples follow the 0, then exactly one pressed pulse.
REQ-030 Release: button 1->0 is held after a debounced press -> level=0 and released=1 for one cycle at E0+5, with toggle and press_count unchanged.
REQ-031 Wrap: 256 clean presses from reset -> press_count=0 and toggle=0 after the final press.
REQ-032 Reset mid-WAIT: reset_n is pulled low 2 samples into WAIT_HIGH -> all outputs are 0 immediately; after release with button held at 1, pressed pulses once at E0+5.
REQ-033 Macro undefined: repeat REQ-028 -> pressed pulses at E0+4.
